// File: rtl/rescan_fifo_pkg.sv
// Shared helpers for the rescan FIFO: pointer width and occupancy arithmetic.
package rescan_fifo_pkg;

  localparam int unsigned MAX_PTR_W = 32;

  typedef logic [MAX_PTR_W-1:0] occ_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Modulo-2^pw distance from tail to head.
  function automatic occ_t occupancy(input occ_t head, input occ_t tail, input int unsigned pw);
    occ_t mask;
    mask = (occ_t'(1) << pw) - occ_t'(1);
    return (head - tail) & mask;
  endfunction

endpackage

// File: rtl/rescan_fifo_ram.sv
// Simple dual-port RAM, single clock, registered read port cleared by reset.
module rescan_fifo_ram #(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned DEPTH     = 256,
  parameter string       pRamStyle = "auto",
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  (* ram_style = pRamStyle *) logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rescan_fifo_sc.sv
// Single-clock FIFO with mark/rewind retention. Optional sticky ovf/unf outputs
// are enabled by defining RESCAN_FIFO_ERR_EN.
module rescan_fifo_sc
  import rescan_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned DEPTH     = 256,
  parameter string       pRamStyle = "auto",
  localparam int unsigned PW       = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             dv,
  output logic             empty,
  input  logic             mark,
  input  logic             rewind,
`ifdef RESCAN_FIFO_ERR_EN
  output logic             ovf,
  output logic             unf,
`endif
  output logic [PW-1:0]    cnt,
  output logic [PW-1:0]    used
);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW-1:0] mk_q, mk_d;
  logic          dv_q;
  logic          wr_acc, rd_acc;

  assign cnt   = PW'(occupancy(occ_t'(wr_q), occ_t'(rd_q), PW));
  assign used  = PW'(occupancy(occ_t'(wr_q), occ_t'(mk_q), PW));
  assign full  = (used == PW'(DEPTH));
  assign empty = (cnt == '0);

  assign wr_acc = wr && !full;
  assign rd_acc = rd && !empty && !rewind;

  // Rewind wins over mark and rd; mark captures the rd pointer after this cycle's read.
  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    mk_d = mk_q;
    if (wr_acc) wr_d = wr_q + PW'(1);
    if (rewind) begin
      rd_d = mk_q;
    end else begin
      if (rd_acc) rd_d = rd_q + PW'(1);
      if (mark)   mk_d = rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      mk_q <= '0;
      dv_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      mk_q <= mk_d;
      dv_q <= rd_acc;
    end
  end

  assign dv = dv_q;

  rescan_fifo_ram #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .pRamStyle (pRamStyle)
  ) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (wr_acc && !rst),
    .waddr_i (wr_q[PW-2:0]),
    .wdata_i (din),
    .re_i    (rd_acc && !rst),
    .raddr_i (rd_q[PW-2:0]),
    .rdata_o (dout)
  );

`ifdef RESCAN_FIFO_ERR_EN
  logic ovf_q, unf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (wr && full)  ovf_q <= 1'b1;
      if (rd && empty) unf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`endif

endmodule

// File: tb/tb_rescan_fifo_sc.sv
// Scoreboard bench for rescan_fifo_sc (DEPTH=8): stimulus pushes expected read data,
// a negedge monitor pops and compares on every dv.
module tb_rescan_fifo_sc;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 8;
  localparam int unsigned PW = $clog2(D) + 1;

  logic          clk = 1'b0;
  logic          rst, wr, rd, mark, rewind;
  logic [W-1:0]  din, dout;
  logic          full, dv, empty;
  logic [PW-1:0] cnt, used;
`ifdef RESCAN_FIFO_ERR_EN
  logic          ovf, unf;
`endif

  int total = 0;
  int bad   = 0;
  logic [W-1:0] sb [$];

  always #5 clk = ~clk;

  rescan_fifo_sc #(
    .WIDTH     (W),
    .DEPTH     (D),
    .pRamStyle ("block")
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .wr     (wr),
    .din    (din),
    .full   (full),
    .rd     (rd),
    .dout   (dout),
    .dv     (dv),
    .empty  (empty),
    .mark   (mark),
    .rewind (rewind),
`ifdef RESCAN_FIFO_ERR_EN
    .ovf    (ovf),
    .unf    (unf),
`endif
    .cnt    (cnt),
    .used   (used)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (dv === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_dv", 32'(dv), 32'd0);
      end else begin
        logic [W-1:0] e;
        e = sb.pop_front();
        chk("dout", 32'(dout), 32'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr = 0; rd = 0; mark = 0; rewind = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic wr1(input logic [W-1:0] d);
    wr = 1; din = d;
    tick();
    wr = 0;
  endtask

  task automatic rd1(input logic [W-1:0] e, input logic m);
    rd = 1; mark = m;
    sb.push_back(e);
    tick();
    rd = 0; mark = 0;
    chk("dv_latency", 32'(dv), 32'd1);
  endtask

  initial begin
    din = '0;
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_cnt",   32'(cnt),   32'd0);
    chk("rst_used",  32'(used),  32'd0);
    chk("rst_dv",    32'(dv),    32'd0);
    chk("rst_dout",  32'(dout),  32'd0);

    // Basic ordering, write visible next cycle
    wr1(16'd0);
    chk("wr_visible", 32'(empty), 32'd0);
    for (int i = 1; i < 4; i++) wr1(16'(i));
    chk("cnt4", 32'(cnt), 32'd4);
    for (int i = 0; i < 4; i++) rd1(16'(i), 1'b0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_cnt",   32'(cnt),   32'd0);
    chk("retained4",   32'(used),  32'd4);
    mark = 1; tick(); mark = 0;
    chk("mark_release", 32'(used), 32'd0);

    // Full, dropped write, retained-full, release by mark, dropped read
    do_reset();
    for (int i = 0; i < 8; i++) wr1(16'(8'h10 + i));
    chk("full_set",  32'(full), 32'd1);
    chk("used8",     32'(used), 32'd8);
    wr1(16'h0099);
    chk("drop_cnt",  32'(cnt),  32'd8);
`ifdef RESCAN_FIFO_ERR_EN
    chk("ovf", 32'(ovf), 32'd1);
`endif
    for (int i = 0; i < 8; i++) rd1(16'(8'h10 + i), 1'b0);
    chk("full_retained", 32'(full),  32'd1);
    chk("empty_after8",  32'(empty), 32'd1);
    rd = 1; tick(); rd = 0;
    chk("drop_rd_dv",   32'(dv),   32'd0);
    chk("drop_rd_hold", 32'(dout), 32'h17);
`ifdef RESCAN_FIFO_ERR_EN
    chk("unf", 32'(unf), 32'd1);
`endif
    mark = 1; tick(); mark = 0;
    chk("mark_used0", 32'(used), 32'd0);
    chk("mark_full0", 32'(full), 32'd0);

    // Mark, read, rewind, re-read
    do_reset();
    wr1(16'h00A1); wr1(16'h00B2); wr1(16'h00C3);
    mark = 1; tick(); mark = 0;
    rd1(16'h00A1, 1'b0);
    rd1(16'h00B2, 1'b0);
    rewind = 1; tick(); rewind = 0;
    chk("rewind_cnt", 32'(cnt), 32'd3);
    chk("rewind_dv",  32'(dv),  32'd0);
    rd1(16'h00A1, 1'b0);
    rd1(16'h00B2, 1'b0);
    rd1(16'h00C3, 1'b0);

    // rd+mark same cycle; rewind beats rd and mark
    do_reset();
    wr1(16'h00A1); wr1(16'h00B2); wr1(16'h00C3);
    rd1(16'h00A1, 1'b1);
    chk("rdmark_used", 32'(used), 32'd2);
    rewind = 1; tick(); rewind = 0;
    rd1(16'h00B2, 1'b0);
    rewind = 1; rd = 1; mark = 1; tick(); idle();
    chk("rw_prio_dv",   32'(dv),   32'd0);
    chk("rw_prio_cnt",  32'(cnt),  32'd2);
    chk("rw_prio_used", 32'(used), 32'd2);
    rd1(16'h00B2, 1'b0);

    // Streaming across wraps with mark on every read
    do_reset();
    wr1(16'd5);
    for (int i = 1; i < 40; i++) begin
      wr = 1; din = 16'(i * 3 + 5);
      rd = 1; mark = 1;
      sb.push_back(16'((i - 1) * 3 + 5));
      tick();
      chk("stream_full", 32'(full), 32'd0);
      chk("stream_cnt",  32'(cnt),  32'd1);
    end
    wr = 0;
    rd1(16'(39 * 3 + 5), 1'b1);
    chk("stream_end_cnt",  32'(cnt),  32'd0);
    chk("stream_end_used", 32'(used), 32'd0);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 5; i++) wr1(16'(i + 16'h40));
    chk("pre_rst_cnt", 32'(cnt), 32'd5);
    rst = 1; tick(); rst = 0;
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_cnt",   32'(cnt),   32'd0);
    chk("mid_rst_used",  32'(used),  32'd0);
    chk("mid_rst_dv",    32'(dv),    32'd0);
    rd = 1; tick(); rd = 0;
    chk("post_rst_rd_dv", 32'(dv), 32'd0);
`ifdef RESCAN_FIFO_ERR_EN
    chk("post_rst_unf", 32'(unf), 32'd1);
    chk("post_rst_ovf", 32'(ovf), 32'd0);
`endif

    tick();
    tick();
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rescan_fifo_sc.md
RESCAN_FIFO_SC -- requirements
Module: rescan_fifo_sc

Interface
REQ-001 SHALL have parameter WIDTH, default 128, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 256, entries; power of two, >=4; other values are unsupported.
REQ-003 SHALL have parameter pRamStyle, default "auto", RAM inference attribute.
REQ-004 SHALL have ports, one per line:
 clk  in  1  sole clock, all logic rising-edge.
 rst  in  1  synchronous active-high reset.
 wr  in  1  write request.
 din  in  WIDTH  write data.
 full  out  1  no free entry.
 rd  in  1  read request.
 dout  out  WIDTH  read data, registered.
 dv  out  1  dout valid strobe.
 empty  out  1  no unread entry.
 mark  in  1  set retention point to the read pointer.
 rewind  in  1  restore the read pointer to the retention point.
 cnt  out  $clog2(DEPTH)+1  unread entries (wr_ptr-rd_ptr).
 used  out  $clog2(DEPTH)+1  retained entries (wr_ptr-mark_ptr).

Function
REQ-005 SHALL hold wr_ptr, rd_ptr and mark_ptr as $clog2(DEPTH)+1-bit counters; the low bits address RAM; arithmetic SHALL be modulo 2^($clog2(DEPTH)+1).
REQ-006 SHALL assert full when used==DEPTH and empty when cnt==0, both derived from registered pointers.
REQ-007 SHALL accept wr when !full: write din at wr_ptr and increment wr_ptr; wr while full SHALL be dropped with no state change.
REQ-008 SHALL accept rd when !empty && !rewind; it SHALL increment rd_ptr and present mem[old rd_ptr] on dout with dv=1 on the next cycle, for a latency of 1.
REQ-009 SHALL drop rd when empty or when rewind is high; dv SHALL be 0 on the following cycle and dout SHALL hold its previous value.
REQ-010 SHALL never overwrite entries in [mark_ptr, wr_ptr); entries already read but not released by mark remain retained.
REQ-011 On mark: mark_ptr SHALL take the post-update rd_ptr, so a concurrent accepted rd releases its entry.
REQ-012 On rewind: rd_ptr SHALL be set to mark_ptr; rewind SHALL take priority over mark and rd in the same cycle.
REQ-013 Simultaneous wr and rd SHALL both be accepted if individually legal; cnt and used SHALL be unchanged by the pair.
REQ-014 A write accepted in cycle N SHALL be readable (empty low) in cycle N+1; no write-to-read bypass is provided.
REQ-015 Pointer wrap SHALL be seamless; full and empty SHALL be correct across any number of wraps.

Reset
REQ-016 On rst, all three pointers SHALL be set to 0, dout to 0 and dv to 0; empty=1, full=0, cnt=0 and used=0 from the following cycle.
REQ-017 rst SHALL override every other input; a reset mid-operation SHALL discard all contents, which are treated as invalid, and RAM SHALL not be cleared.

Configuration
REQ-018 When RESCAN_FIFO_ERR_EN is defined, the block SHALL add outputs ovf and unf: sticky bits set by a dropped wr (full) or a dropped rd (empty) respectively, cleared only by rst.
REQ-019 When RESCAN_FIFO_ERR_EN is undefined, ovf and unf and their logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-020 A shared package rescan_fifo_pkg SHALL hold the pointer-width function and the typedef for the occupancy-count type.
REQ-021 Storage SHALL be one sub-module rescan_fifo_ram: a simple dual-port RAM with one clock and a registered read port, carrying the pRamStyle attribute.

Verification
REQ-022 Write 0..3, then read 4 times -> dout 0,1,2,3, each with dv one cycle after rd; then empty=1 and cnt=0.
REQ-023 DEPTH=8: write 8 -> full=1 and used=8; a 9th write is dropped (ovf=1 if enabled); read 8 without mark -> full stays 1; mark -> used=0 and full=0.
REQ-024 Write A,B,C; mark; read A,B; rewind -> cnt=3, and re-read yields A,B,C.
REQ-025 With rd+mark in the same cycle on A, then rewind -> the next read returns B; with rewind+rd+mark together -> rd_ptr=mark_ptr and dv=0 next cycle.
REQ-026 DEPTH=8: stream 40 words with wr and rd concurrent, marking every read -> data in order across 5 wraps, never full, and cnt<=1 throughout.
REQ-027 Assert rst with cnt=5 -> the next cycle shows empty=1, cnt=0, used=0 and dv=0; a rd in that cycle produces dv=0 (unf=1 if enabled).
